arp_transmit: RTL
=================

// Module: arp_transmit
// PURPOSE
//  Builds and streams ARP request/reply frames as 32-bit big-endian words (byte 0 in [31:24]).
//  Pairs with the receive-side ARP path: a decoded ARP request triggers a reply; an unresolved
//  address triggers a request. Output goes to the MAC transmit path, which appends the FCS.
//  Frame: 14 B Ethernet header + 28 B ARP + 18 B zero pad = 60 B = 15 words.
// PARAMETERS
//  IFG_CYCLES  3   idle cycles forced after the eof word is accepted and before the next sof (>=1)
// PORTS
//  clock        in   1   system clock; all logic on posedge
//  reset        in   1   synchronous, active-high
//  reqvalid     in   1   1-cycle pulse: send frame described by reqop/reqhwaddr/reqipaddr
//  reqop        in   1   0 = ARP request, 1 = ARP reply
//  reqhwaddr    in   48  target MAC (reply only; ignored for request)
//  reqipaddr    in   32  target IP
//  inthwaddr    in   48  own MAC (sampled when frame starts)
//  intipaddr    in   32  own IP, 0 until DHCP ack (sampled when frame starts)
//  txready      in   1   downstream accepts word when high
//  validout     out  1   dataout holds a valid word
//  sof          out  1   high with word 0
//  eof          out  1   high with word 14
//  dataout      out  32  frame word
//  busy         out  1   frame in flight or gap running
//  dropped      out  1   1-cycle pulse: request discarded (slot full or reply with intipaddr==0)
// BEHAVIOUR
//  Reset: validout/sof/eof/busy/dropped = 0, dataout = 0, slot empty, state IDLE, counters 0.
//  Slot: one-entry hold register {op, hwaddr, ipaddr}, written on reqvalid when empty.
//   - reqvalid with slot full -> dropped pulse next cycle, slot unchanged.
//   - reqvalid with reqop=1 and intipaddr==0 -> dropped pulse, not stored.
//   - slot freed in the cycle its frame enters SEND; a new reqvalid in that same cycle is stored.
//  FSM: IDLE -> SEND when slot full; SEND -> GAP on accepted word 14; GAP -> IDLE after IFG_CYCLES.
//   - Latency: reqvalid at cycle t (IDLE, slot empty) -> validout=1 with word 0 at t+2.
//  Handshake: word index wc (0..14) advances only when validout && txready. dataout/sof/eof
//   hold stable while txready=0. validout is never deasserted mid-frame.
//  Word map (request: DA=FF..FF, THA=0, OPER=0001; reply: DA=THA=hwaddr, OPER=0002):
//   w0 DA[47:16] | w1 DA[15:0],SA[47:32] | w2 SA[31:0] | w3 0806,0001 | w4 0800,06,04
//   w5 OPER,SHA[47:32] | w6 SHA[31:0] | w7 SPA | w8 THA[47:16] | w9 THA[15:0],TPA[31:16]
//   w10 TPA[15:0],0000 | w11..w14 00000000. SA=SHA=inthwaddr, SPA=intipaddr, TPA=ipaddr.
//  inthwaddr/intipaddr captured on IDLE->SEND; changes mid-frame have no effect on that frame.
//  busy = (state != IDLE). Reset mid-frame: output drops to 0 in the next cycle, no eof emitted,
//   slot cleared.
// STRUCTURE
//  Shared include ethconst.vh: ETH_TYPE_ARP 16'h0806, ARP_HTYPE 16'h0001, ARP_PTYPE 16'h0800,
//   ARP_HLEN 8'h06, ARP_PLEN 8'h04, ARP_OP_REQ 16'h0001, ARP_OP_REP 16'h0002, ARP_FRAME_WORDS 15.
//  One sub-module: arp_tx_slot (one-entry hold register with full flag and drop logic).
//  Word mux: a combinational case on wc in the top module, registered onto dataout.
// TESTING
//  1 Reply: intipaddr=C0A8010A, inthwaddr=001122334455, reqop=1, reqhwaddr=AABBCCDDEEFF,
//    reqipaddr=C0A80101, txready=1 -> 15 words back-to-back; w0=AABBCCDD, w3=08060001,
//    w5=00020011, w7=C0A8010A, w10=01010000, sof on w0, eof on w14.
//  2 Request: reqop=0, reqipaddr=C0A801FE -> w0=FFFFFFFF, w1=FFFF0011, w8=00000000,
//    w9=0000C0A8, w10=01FE0000.
//  3 Backpressure: txready toggles 1,0,0,1 through the frame -> no words lost or repeated;
//    dataout stable while txready=0; total 15 accepted words.
//  4 Queue: three reqvalid pulses during frame 1 -> 2nd held and sent after IFG_CYCLES=3
//    idle cycles; 3rd gives dropped=1; exactly 2 frames emitted.
//  5 Reply with intipaddr=0 -> dropped=1, validout stays 0, busy stays 0.
//  6 Reset asserted at w6 -> next cycle validout=0, busy=0; a new reqvalid after reset sends a
//    complete frame starting at w0.

Source files
------------

// File: rtl/arp_transmit_pkg.sv
// rtl/arp_transmit_pkg.sv - shared Ethernet/ARP constants, request record and FSM state type
package arp_transmit_pkg;

    localparam logic [15:0] ETH_TYPE_ARP    = 16'h0806;
    localparam logic [15:0] ARP_HTYPE       = 16'h0001;
    localparam logic [15:0] ARP_PTYPE       = 16'h0800;
    localparam logic [7:0]  ARP_HLEN        = 8'h06;
    localparam logic [7:0]  ARP_PLEN        = 8'h04;
    localparam logic [15:0] ARP_OP_REQ      = 16'h0001;
    localparam logic [15:0] ARP_OP_REP      = 16'h0002;
    localparam int          ARP_FRAME_WORDS = 15;

    // op: 0 = request, 1 = reply
    typedef struct packed {
        logic        op;
        logic [47:0] hwaddr;
        logic [31:0] ipaddr;
    } arp_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } tx_state_t;

endpackage

// File: rtl/arp_transmit_if.sv
// rtl/arp_transmit_if.sv - request, own-address and transmit stream signals of the ARP transmitter
interface arp_transmit_if;
    logic        reqvalid;
    logic        reqop;
    logic [47:0] reqhwaddr;
    logic [31:0] reqipaddr;
    logic [47:0] inthwaddr;
    logic [31:0] intipaddr;
    logic        txready;
    logic        validout;
    logic        sof;
    logic        eof;
    logic [31:0] dataout;
    logic        busy;
    logic        dropped;

    modport slave (
        input  reqvalid, reqop, reqhwaddr, reqipaddr, inthwaddr, intipaddr, txready,
        output validout, sof, eof, dataout, busy, dropped
    );

    modport master (
        output reqvalid, reqop, reqhwaddr, reqipaddr, inthwaddr, intipaddr, txready,
        input  validout, sof, eof, dataout, busy, dropped
    );
endinterface

// File: rtl/arp_tx_slot.sv
// rtl/arp_tx_slot.sv - one-entry request hold register with full flag and drop pulse
module arp_tx_slot
    import arp_transmit_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     wr,
    input  arp_req_t wr_req,
    input  logic     own_ip_zero,
    input  logic     take,
    output logic     full,
    output arp_req_t rd_req,
    output logic     dropped
);

    // A take frees the slot in the same cycle, so a coincident write is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            full    <= 1'b0;
            rd_req  <= '0;
            dropped <= 1'b0;
        end else begin
            dropped <= 1'b0;
            if (take) begin
                full <= 1'b0;
            end
            if (wr) begin
                if (wr_req.op && own_ip_zero) begin
                    dropped <= 1'b1;
                end else if (full && !take) begin
                    dropped <= 1'b1;
                end else begin
                    full   <= 1'b1;
                    rd_req <= wr_req;
                end
            end
        end
    end

endmodule

// File: rtl/arp_transmit.sv
// rtl/arp_transmit.sv - builds and streams 60-byte ARP request/reply frames as 32-bit words
module arp_transmit
    import arp_transmit_pkg::*;
#(
    parameter int IFG_CYCLES = 3
) (
    input logic            clock,
    input logic            reset,
    arp_transmit_if.slave  bus
);

    localparam logic [3:0] LAST_WORD = 4'(ARP_FRAME_WORDS - 1);
    // GAP covers IFG_CYCLES-1 cycles; the IDLE cycle that launches the next frame is the last idle one.
    localparam logic [7:0] GAP_LAST  = 8'((IFG_CYCLES > 1) ? IFG_CYCLES - 2 : 0);

    tx_state_t   state;
    logic [3:0]  wc;
    logic [7:0]  gcnt;
    logic        validout_r, sof_r, eof_r;
    logic [31:0] dataout_r;
    arp_req_t    f_req;
    logic [47:0] f_hw;
    logic [31:0] f_ip;

    logic        slot_full, slot_dropped, take;
    arp_req_t    slot_req, in_req;

    arp_req_t    src_req;
    logic [47:0] src_hw, da, tha;
    logic [31:0] src_ip, word_nxt;
    logic [15:0] oper;
    logic [3:0]  idx;

    assign in_req = '{op: bus.reqop, hwaddr: bus.reqhwaddr, ipaddr: bus.reqipaddr};
    assign take   = (state == ST_IDLE) && slot_full;

    arp_tx_slot u_slot (
        .clock       (clock),
        .reset       (reset),
        .wr          (bus.reqvalid),
        .wr_req      (in_req),
        .own_ip_zero (bus.intipaddr == 32'd0),
        .take        (take),
        .full        (slot_full),
        .rd_req      (slot_req),
        .dropped     (slot_dropped)
    );

    // In IDLE the first word comes straight from the slot and live own addresses.
    always_comb begin
        src_req = f_req;
        src_hw  = f_hw;
        src_ip  = f_ip;
        idx     = wc + 4'd1;
        if (state == ST_IDLE) begin
            src_req = slot_req;
            src_hw  = bus.inthwaddr;
            src_ip  = bus.intipaddr;
            idx     = 4'd0;
        end
        da   = src_req.op ? src_req.hwaddr : 48'hFFFF_FFFF_FFFF;
        tha  = src_req.op ? src_req.hwaddr : 48'h0;
        oper = src_req.op ? ARP_OP_REP : ARP_OP_REQ;
        case (idx)
            4'd0:    word_nxt = da[47:16];
            4'd1:    word_nxt = {da[15:0], src_hw[47:32]};
            4'd2:    word_nxt = src_hw[31:0];
            4'd3:    word_nxt = {ETH_TYPE_ARP, ARP_HTYPE};
            4'd4:    word_nxt = {ARP_PTYPE, ARP_HLEN, ARP_PLEN};
            4'd5:    word_nxt = {oper, src_hw[47:32]};
            4'd6:    word_nxt = src_hw[31:0];
            4'd7:    word_nxt = src_ip;
            4'd8:    word_nxt = tha[47:16];
            4'd9:    word_nxt = {tha[15:0], src_req.ipaddr[31:16]};
            4'd10:   word_nxt = {src_req.ipaddr[15:0], 16'h0000};
            default: word_nxt = 32'h0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            wc         <= 4'd0;
            gcnt       <= 8'd0;
            validout_r <= 1'b0;
            sof_r      <= 1'b0;
            eof_r      <= 1'b0;
            dataout_r  <= 32'd0;
            f_req      <= '0;
            f_hw       <= 48'd0;
            f_ip       <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (slot_full) begin
                        state      <= ST_SEND;
                        f_req      <= slot_req;
                        f_hw       <= bus.inthwaddr;
                        f_ip       <= bus.intipaddr;
                        wc         <= 4'd0;
                        validout_r <= 1'b1;
                        sof_r      <= 1'b1;
                        eof_r      <= 1'b0;
                        dataout_r  <= word_nxt;
                    end
                end
                ST_SEND: begin
                    if (bus.txready) begin
                        if (wc == LAST_WORD) begin
                            state      <= (IFG_CYCLES > 1) ? ST_GAP : ST_IDLE;
                            gcnt       <= 8'd0;
                            wc         <= 4'd0;
                            validout_r <= 1'b0;
                            sof_r      <= 1'b0;
                            eof_r      <= 1'b0;
                            dataout_r  <= 32'd0;
                        end else begin
                            wc        <= idx;
                            sof_r     <= 1'b0;
                            eof_r     <= (idx == LAST_WORD);
                            dataout_r <= word_nxt;
                        end
                    end
                end
                ST_GAP: begin
                    if (gcnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gcnt <= gcnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.validout = validout_r;
    assign bus.sof      = sof_r;
    assign bus.eof      = eof_r;
    assign bus.dataout  = dataout_r;
    assign bus.busy     = (state != ST_IDLE);
    assign bus.dropped  = slot_dropped;

endmodule
